// File: rtl/traf_ctrl_actuated.sv
// traf_ctrl_actuated
// Sensor-actuated highway/side-road traffic-light controller.
// Highway green rests until a side-road or pedestrian request is seen. Side
// green is stretched by vehicle presence between SG_MIN and SG_MAX cycles.
// Every green handover goes through yellow and then an all-red clearance.
// A night mode flashes the highway yellow lamp.
//
// Ports:
//   clk           clock
//   rst_n         synchronous active-low reset
//   side_req      side-road vehicle detector (pulse or level)
//   side_present  vehicle currently waiting on the side-road stop line
//   ped_req       pedestrian push-button
//   flash_en      night flashing-yellow request
//   highway[1:0]  highway lamp: 10 green, 01 yellow, 00 red
//   side[1:0]     side lamp, same encoding
//   walk          pedestrian walk indication (side green only)
//   state_o[2:0]  HG=0 HY=1 AR1=2 SG=3 SY=4 AR2=5 FLASH=6
module traf_ctrl_actuated #(
  parameter int CNT_W      = 8,
  parameter int HG_MIN     = 10,
  parameter int YELLOW     = 3,
  parameter int ALL_RED    = 1,
  parameter int SG_MIN     = 4,
  parameter int SG_MAX     = 10,
  parameter int FLASH_HALF = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       side_req,
  input  logic       side_present,
  input  logic       ped_req,
  input  logic       flash_en,
  output logic [1:0] highway,
  output logic [1:0] side,
  output logic       walk,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    S_HG    = 3'd0,
    S_HY    = 3'd1,
    S_AR1   = 3'd2,
    S_SG    = 3'd3,
    S_SY    = 3'd4,
    S_AR2   = 3'd5,
    S_FLASH = 3'd6
  } state_t;

  localparam logic [1:0] LAMP_G = 2'b10;
  localparam logic [1:0] LAMP_Y = 2'b01;
  localparam logic [1:0] LAMP_R = 2'b00;

  // Timer load values: a state lasting N cycles loads N-1 on entry
  localparam logic [CNT_W-1:0] L_HG    = CNT_W'(HG_MIN - 1);
  localparam logic [CNT_W-1:0] L_Y     = CNT_W'(YELLOW - 1);
  localparam logic [CNT_W-1:0] L_AR    = CNT_W'(ALL_RED - 1);
  localparam logic [CNT_W-1:0] L_SG    = CNT_W'(SG_MAX - 1);
  localparam logic [CNT_W-1:0] L_FLASH = CNT_W'(FLASH_HALF - 1);
  // Once cnt has fallen to this value, SG_MIN cycles of side green are done
  localparam logic [CNT_W-1:0] L_SG_EXT = CNT_W'(SG_MAX - SG_MIN);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_req_q;
  logic             r_phase;

  state_t           w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_cnt_dec;
  logic             w_req_nxt;
  logic             w_phase_nxt;
  logic             w_req_pend;
  logic             w_cnt_zero;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_HG;
      r_cnt   <= L_HG;
      r_req_q <= 1'b0;
      r_phase <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_req_q <= w_req_nxt;
      r_phase <= w_phase_nxt;
    end
  end

  // Next-state, timer, request latch and flash phase
  always_comb begin
    w_cnt_zero  = (r_cnt == '0);
    w_cnt_dec   = w_cnt_zero ? '0 : r_cnt - 1'b1;
    w_req_pend  = r_req_q | side_req | ped_req;
    w_state_nxt = r_state;
    w_cnt_nxt   = w_cnt_dec;
    w_phase_nxt = r_phase;

    case (r_state)
      S_HG: begin
        if (flash_en) begin
          w_state_nxt = S_FLASH;
          w_cnt_nxt   = L_FLASH;
          w_phase_nxt = 1'b1;
        end else if (w_cnt_zero && w_req_pend) begin
          w_state_nxt = S_HY;
          w_cnt_nxt   = L_Y;
        end
      end
      S_HY: begin
        if (w_cnt_zero) begin
          w_state_nxt = S_AR1;
          w_cnt_nxt   = L_AR;
        end
      end
      S_AR1: begin
        if (w_cnt_zero) begin
          w_state_nxt = S_SG;
          w_cnt_nxt   = L_SG;
        end
      end
      S_SG: begin
        if (w_cnt_zero || ((r_cnt <= L_SG_EXT) && !side_present)) begin
          w_state_nxt = S_SY;
          w_cnt_nxt   = L_Y;
        end
      end
      S_SY: begin
        if (w_cnt_zero) begin
          w_state_nxt = S_AR2;
          w_cnt_nxt   = L_AR;
        end
      end
      S_AR2: begin
        if (w_cnt_zero) begin
          w_state_nxt = S_HG;
          w_cnt_nxt   = L_HG;
        end
      end
      S_FLASH: begin
        if (!flash_en) begin
          w_state_nxt = S_AR2;
          w_cnt_nxt   = L_AR;
        end else if (w_cnt_zero) begin
          w_cnt_nxt   = L_FLASH;
          w_phase_nxt = ~r_phase;
        end
      end
      default: begin
        w_state_nxt = S_HG;
        w_cnt_nxt   = L_HG;
      end
    endcase

    // Clearing on AR1->SG wins over a request arriving in that same cycle
    if ((r_state == S_AR1) && (w_state_nxt == S_SG)) begin
      w_req_nxt = 1'b0;
    end else if ((r_state != S_SG) && (side_req || ped_req)) begin
      w_req_nxt = 1'b1;
    end else begin
      w_req_nxt = r_req_q;
    end
  end

  // Output decode of registered state
  always_comb begin
    highway = LAMP_R;
    side    = LAMP_R;
    walk    = 1'b0;
    state_o = r_state;
    case (r_state)
      S_HG:    highway = LAMP_G;
      S_HY:    highway = LAMP_Y;
      S_SG: begin
        side = LAMP_G;
        walk = 1'b1;
      end
      S_SY:    side    = LAMP_Y;
      S_FLASH: highway = r_phase ? LAMP_Y : LAMP_R;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_traf_ctrl_actuated.sv
module tb_traf_ctrl_actuated;

  localparam logic [2:0] HG = 3'd0, HY = 3'd1, AR1 = 3'd2, SG = 3'd3,
                         SY = 3'd4, AR2 = 3'd5, FL = 3'd6;
  localparam logic [1:0] G = 2'b10, Y = 2'b01, R = 2'b00;

  typedef struct {
    logic       sr, sp, pr, fl, rn;
    logic [2:0] st;
    logic [1:0] hw, sd;
    logic       wk;
    int         id;
    int         idx;
  } vec_t;

  logic       clk;
  logic       rst_n, side_req, side_present, ped_req, flash_en;
  logic [1:0] highway, side;
  logic       walk;
  logic [2:0] state_o;

  vec_t tbl[$];
  vec_t sb[$];
  int   cur_id;
  bit   drive_done;
  int   checks;
  int   errors;

  traf_ctrl_actuated #(
    .CNT_W(8), .HG_MIN(10), .YELLOW(3), .ALL_RED(1),
    .SG_MIN(4), .SG_MAX(10), .FLASH_HALF(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .side_req(side_req),
    .side_present(side_present), .ped_req(ped_req), .flash_en(flash_en),
    .highway(highway), .side(side), .walk(walk), .state_o(state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Append n identical cycles; lamps come from the decode table of the state,
  // fh gives the highway lamp expected while flashing.
  task automatic add(input int n, input logic [2:0] st, input logic sr,
                     input logic sp, input logic pr, input logic fl,
                     input logic rn, input logic [1:0] fh);
    vec_t v;
    for (int i = 0; i < n; i++) begin
      v.sr = sr; v.sp = sp; v.pr = pr; v.fl = fl; v.rn = rn;
      v.st = st; v.hw = R; v.sd = R; v.wk = 1'b0;
      case (st)
        HG: v.hw = G;
        HY: v.hw = Y;
        SG: begin v.sd = G; v.wk = 1'b1; end
        SY: v.sd = Y;
        FL: v.hw = fh;
        default: ;
      endcase
      v.id  = cur_id;
      v.idx = tbl.size();
      tbl.push_back(v);
    end
  endtask

  // Driver: one vector per cycle, expected outputs pushed to the scoreboard
  initial begin
    drive_done = 1'b0;
    rst_n = 1'b0; side_req = 1'b0; side_present = 1'b0;
    ped_req = 1'b0; flash_en = 1'b0;

    // 1: idle rest in highway green, then reset
    cur_id = 1;
    add(100, HG, 0, 0, 0, 0, 1, R);
    add(1,   HG, 0, 0, 0, 0, 0, R);
    // 2: side_req at cycle 2, nobody present -> minimum side green
    cur_id = 2;
    add(2,  HG, 0, 0, 0, 0, 1, R);
    add(1,  HG, 1, 0, 0, 0, 1, R);
    add(7,  HG, 0, 0, 0, 0, 1, R);
    add(3,  HY, 0, 0, 0, 0, 1, R);
    add(1,  AR1, 0, 0, 0, 0, 1, R);
    add(4,  SG, 0, 0, 0, 0, 1, R);
    add(3,  SY, 0, 0, 0, 0, 1, R);
    add(1,  AR2, 0, 0, 0, 0, 1, R);
    add(12, HG, 0, 0, 0, 0, 1, R);
    add(1,  HG, 0, 0, 0, 0, 0, R);
    // 3: vehicle always present -> maximum side green
    cur_id = 3;
    add(2,  HG, 0, 1, 0, 0, 1, R);
    add(1,  HG, 1, 1, 0, 0, 1, R);
    add(7,  HG, 0, 1, 0, 0, 1, R);
    add(3,  HY, 0, 1, 0, 0, 1, R);
    add(1,  AR1, 0, 1, 0, 0, 1, R);
    add(10, SG, 0, 1, 0, 0, 1, R);
    add(3,  SY, 0, 1, 0, 0, 1, R);
    add(1,  AR2, 0, 1, 0, 0, 1, R);
    add(5,  HG, 0, 1, 0, 0, 1, R);
    add(1,  HG, 0, 0, 0, 0, 0, R);
    // 4: late ped request, requests during SG ignored, HG rests afterwards
    cur_id = 4;
    add(40, HG, 0, 0, 0, 0, 1, R);
    add(1,  HG, 0, 0, 1, 0, 1, R);
    add(3,  HY, 0, 0, 0, 0, 1, R);
    add(1,  AR1, 0, 0, 0, 0, 1, R);
    add(1,  SG, 0, 0, 0, 0, 1, R);
    add(1,  SG, 1, 0, 0, 0, 1, R);
    add(1,  SG, 0, 0, 1, 0, 1, R);
    add(1,  SG, 1, 0, 1, 0, 1, R);
    add(3,  SY, 0, 0, 0, 0, 1, R);
    add(1,  AR2, 0, 0, 0, 0, 1, R);
    add(20, HG, 0, 0, 0, 0, 1, R);
    add(1,  HG, 0, 0, 0, 0, 0, R);
    // 5: flash requested in SG, deferred to HG; request latched while flashing
    cur_id = 5;
    add(2,  HG, 0, 0, 0, 0, 1, R);
    add(1,  HG, 1, 0, 0, 0, 1, R);
    add(7,  HG, 0, 0, 0, 0, 1, R);
    add(3,  HY, 0, 0, 0, 0, 1, R);
    add(1,  AR1, 0, 0, 0, 0, 1, R);
    add(4,  SG, 0, 0, 0, 1, 1, R);
    add(3,  SY, 0, 0, 0, 1, 1, R);
    add(1,  AR2, 0, 0, 0, 1, 1, R);
    add(1,  HG, 0, 0, 0, 1, 1, R);
    add(2,  FL, 0, 0, 0, 1, 1, Y);
    add(1,  FL, 0, 0, 0, 1, 1, R);
    add(1,  FL, 1, 0, 0, 1, 1, R);
    add(2,  FL, 0, 0, 0, 1, 1, Y);
    add(1,  FL, 0, 0, 0, 1, 1, R);
    add(1,  FL, 0, 0, 0, 0, 1, R);
    add(1,  AR2, 0, 0, 0, 0, 1, R);
    add(10, HG, 0, 0, 0, 0, 1, R);
    add(3,  HY, 0, 0, 0, 0, 1, R);
    add(1,  AR1, 0, 0, 0, 0, 1, R);
    add(4,  SG, 0, 0, 0, 0, 1, R);
    add(3,  SY, 0, 0, 0, 0, 1, R);
    add(1,  AR2, 0, 0, 0, 0, 1, R);
    add(3,  HG, 0, 0, 0, 0, 1, R);
    add(1,  HG, 0, 0, 0, 0, 0, R);
    // 6: reset mid-SG restarts HG_MIN; reset in HY clears the pending request
    cur_id = 6;
    add(2,  HG, 0, 0, 0, 0, 1, R);
    add(1,  HG, 1, 0, 0, 0, 1, R);
    add(7,  HG, 0, 0, 0, 0, 1, R);
    add(3,  HY, 0, 0, 0, 0, 1, R);
    add(1,  AR1, 0, 0, 0, 0, 1, R);
    add(1,  SG, 0, 1, 0, 0, 1, R);
    add(1,  SG, 0, 1, 0, 0, 0, R);
    add(1,  HG, 1, 0, 0, 0, 1, R);
    add(9,  HG, 0, 0, 0, 0, 1, R);
    add(1,  HY, 0, 0, 0, 0, 1, R);
    add(1,  HY, 0, 0, 0, 0, 0, R);
    add(15, HG, 0, 0, 0, 0, 1, R);

    repeat (2) @(posedge clk);
    foreach (tbl[i]) begin
      @(posedge clk);
      #2;
      rst_n        = tbl[i].rn;
      side_req     = tbl[i].sr;
      side_present = tbl[i].sp;
      ped_req      = tbl[i].pr;
      flash_en     = tbl[i].fl;
      sb.push_back(tbl[i]);
    end
    @(posedge clk);
    #2;
    side_req = 1'b0; ped_req = 1'b0; flash_en = 1'b0; side_present = 1'b0;
    drive_done = 1'b1;
  end

  // Monitor: pops one expectation per cycle, mid-cycle on the falling edge
  initial begin
    vec_t e;
    bit   finished;
    checks   = 0;
    errors   = 0;
    finished = 1'b0;
    for (int c = 0; c < 2000 && !finished; c++) begin
      @(negedge clk);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        checks++;
        if (state_o !== e.st || highway !== e.hw || side !== e.sd || walk !== e.wk) begin
          errors++;
          $display("FAIL test%0d vec%0d: got state=%0d hw=%b side=%b walk=%b, want state=%0d hw=%b side=%b walk=%b",
                   e.id, e.idx, state_o, highway, side, walk, e.st, e.hw, e.sd, e.wk);
        end
      end else if (drive_done) begin
        finished = 1'b1;
      end
    end
    if (!finished) begin
      errors++;
      $display("FAIL timeout: got %0d pending expectations, want 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
